// File: rtl/uc_secuenciador.sv
// ============================================================================
// Module   : uc_secuenciador
// Brief    : Multicycle sequencing control unit for the 8-bit CPU datapath.
//            Paces FETCH / EXEC / WAIT_STEP / HALTED and decodes the opcode
//            and Z flag into datapath controls during the single EXEC cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uc_secuenciador #(
    parameter int FETCH_WAIT = 1,   // cycles spent in FETCH (1..15)
    parameter int CNT_W      = 16   // retired-instruction counter width
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active-low
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [5:0]       opcode,
    input  logic             z,
    output logic             pc_en,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op_alu,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_EXEC      = 3'd2,
        S_WAIT_STEP = 3'd3,
        S_HALTED    = 3'd4
    } state_t;

    localparam logic [3:0] c_fetch_reload = 4'(FETCH_WAIT - 1);

    localparam logic [5:0] c_op_nop  = 6'b000000;
    localparam logic [5:0] c_op_li   = 6'b010000;
    localparam logic [5:0] c_op_j    = 6'b100000;
    localparam logic [5:0] c_op_jz   = 6'b100001;
    localparam logic [5:0] c_op_jnz  = 6'b100010;
    localparam logic [5:0] c_op_halt = 6'b111111;

    state_t           state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             illegal_q, illegal_d;

    logic             w_op_halt;
    logic             w_op_illegal;

    // State, fetch counter, retired counter and sticky illegal flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            fcnt_q    <= 4'd0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    // Datapath controls: idle values everywhere except in EXEC, where the
    // opcode (and z for conditional jumps) selects them. Being purely
    // combinational from state_q, an async reset drops the write enables
    // in the same cycle.
    always_comb begin
        pc_en        = 1'b0;
        s_inc        = 1'b1;
        s_inm        = 1'b0;
        we3          = 1'b0;
        wez          = 1'b0;
        op_alu       = 3'b000;
        w_op_halt    = 1'b0;
        w_op_illegal = 1'b0;
        if (state_q == S_EXEC) begin
            pc_en = 1'b1;
            if (opcode[5:3] == 3'b001) begin
                op_alu = opcode[2:0];
                we3    = 1'b1;
                wez    = 1'b1;
            end else begin
                case (opcode)
                    c_op_nop: ;
                    c_op_li: begin
                        s_inm = 1'b1;
                        we3   = 1'b1;
                    end
                    c_op_j:   s_inc = 1'b0;
                    c_op_jz:  s_inc = ~z;
                    c_op_jnz: s_inc = z;
                    c_op_halt: begin
                        pc_en     = 1'b0;   // PC stays parked on HALT
                        w_op_halt = 1'b1;
                    end
                    default:  w_op_illegal = 1'b1;  // behaves as NOP
                endcase
            end
        end
    end

    // Next-state sequencing, fetch-wait countdown and retirement bookkeeping.
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    fcnt_d  = c_fetch_reload;
                end
            end
            S_FETCH: begin
                if (fcnt_q != 4'd0) begin
                    fcnt_d = fcnt_q - 4'd1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (count_q != '1) begin
                    count_d = count_q + 1'b1;
                end
                if (w_op_illegal) begin
                    illegal_d = 1'b1;
                end
                if (w_op_halt) begin
                    state_d = S_HALTED;
                end else if (step_mode) begin
                    state_d = S_WAIT_STEP;
                end else begin
                    state_d = S_FETCH;
                    fcnt_d  = c_fetch_reload;
                end
            end
            S_WAIT_STEP: begin
                if (step || !step_mode) begin
                    state_d = S_FETCH;
                    fcnt_d  = c_fetch_reload;
                end
            end
            S_HALTED: ;
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                         (state_q == S_WAIT_STEP);
    assign halted      = (state_q == S_HALTED);
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

`default_nettype wire
